// File: rtl/lgdst_iq_pkg.sv
// Shared mode encodings and sizing helpers for the I/Q transmit serializer.
package lgdst_iq_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_MUTE  = 2'd3
    } mode_e;

    localparam int UF_W = 8;
    localparam logic [UF_W-1:0] UF_MAX = '1;

    // Slot counter width for 2*num_ch half-word slots per frame.
    function automatic int slot_w(input int num_ch);
        return (2 * num_ch > 1) ? $clog2(2 * num_ch) : 1;
    endfunction

endpackage

// File: rtl/lgdst_iq_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy counter; latency 1 cycle from push to non-empty.
// Push while full and pop while empty are ignored; push and pop together keep occupancy unchanged.
module lgdst_iq_sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o    = (cnt_q == DEPTH_C);
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/lgdst_iq_tx_serializer.sv
// I/Q transmit serializer: buffered full-width samples leave as MSB/LSB half-words with a frame strobe.
// Outputs trail the slot counter by one cycle; source is latched per frame at the last-slot fetch.
module lgdst_iq_tx_serializer
    import lgdst_iq_pkg::*;
#(
    parameter int                  SAMPLE_W      = 12,
    parameter int                  BUS_W         = 6,
    parameter int                  NUM_CH        = 1,
    parameter int                  FIFO_DEPTH    = 8,
    parameter int                  WARMUP_CYCLES = 30,
    parameter logic [SAMPLE_W-1:0] RAMP_INIT_I   = 12'hE80,
    parameter logic [SAMPLE_W-1:0] RAMP_INIT_Q   = 12'h5C0,
    parameter int                  RAMP_STEP_I   = 3,
    parameter int                  RAMP_STEP_Q   = 7
) (
    input  logic                       rf_data_clk,
    input  logic                       rst_b,
    input  logic [1:0]                 mode,
    input  logic [SAMPLE_W-1:0]        const_i,
    input  logic [SAMPLE_W-1:0]        const_q,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_i,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_q,
    input  logic                       clr_cnt,
    output logic                       tx_enable,
    output logic                       tx_frame,
    output logic [BUS_W-1:0]           tx_data_i,
    output logic [BUS_W-1:0]           tx_data_q,
    output logic [UF_W-1:0]            underflow_cnt
);
    localparam int                  NSLOT     = 2 * NUM_CH;
    localparam int                  SLW       = slot_w(NUM_CH);
    localparam int                  DW        = NUM_CH * SAMPLE_W;
    localparam logic [SLW-1:0]      LAST_SLOT = SLW'(NSLOT - 1);
    localparam logic [7:0]          WU_INIT   = 8'(WARMUP_CYCLES);
    localparam logic [SAMPLE_W-1:0] STEP_I    = SAMPLE_W'(RAMP_STEP_I);
    localparam logic [SAMPLE_W-1:0] STEP_Q    = SAMPLE_W'(RAMP_STEP_Q);

    logic [SLW-1:0]      slot_q, slot_d;
    logic [7:0]          wu_q, wu_d;
    logic                en_q, en_d;
    logic [DW-1:0]       hold_i_q, hold_i_d, hold_q_q, hold_q_d;
    logic [SAMPLE_W-1:0] ramp_i_q, ramp_i_d, ramp_q_q, ramp_q_d;
    logic [UF_W-1:0]     uf_q, uf_d;
    logic [BUS_W-1:0]    txi_q, txi_d, txq_q, txq_d;
    logic                frame_q, frame_d;
    logic [SAMPLE_W-1:0] smp_i, smp_q;
    logic                last_slot, uf_inc;
    mode_e               src;
    logic                fifo_full, fifo_empty;
    logic [2*DW-1:0]     fifo_dat;

    assign last_slot = (slot_q == LAST_SLOT);
    assign src       = en_q ? mode_e'(mode) : MODE_RAMP;

    lgdst_iq_sync_fifo #(
        .W     (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (rf_data_clk),
        .rst_ni     (rst_b),
        .push_i     (s_valid & s_ready),
        .push_dat_i ({s_q, s_i}),
        .pop_i      (last_slot & en_q),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Slot 2c/2c+1 carry channel c's MSB/LSB; the first NUM_CH slots are strobed.
    always_comb begin
        smp_i = hold_i_q[SAMPLE_W-1:0];
        smp_q = hold_q_q[SAMPLE_W-1:0];
        for (int c = 1; c < NUM_CH; c++) begin
            if ((int'(slot_q) >> 1) == c) begin
                smp_i = hold_i_q[c*SAMPLE_W +: SAMPLE_W];
                smp_q = hold_q_q[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign txi_d   = slot_q[0] ? smp_i[BUS_W-1:0] : smp_i[SAMPLE_W-1 -: BUS_W];
    assign txq_d   = slot_q[0] ? smp_q[BUS_W-1:0] : smp_q[SAMPLE_W-1 -: BUS_W];
    assign frame_d = (int'(slot_q) < NUM_CH);
    assign slot_d  = last_slot ? '0 : slot_q + SLW'(1);
    assign wu_d    = (wu_q != '0) ? wu_q - 8'd1 : wu_q;
    assign en_d    = en_q | (wu_d == '0);

    always_comb begin
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        ramp_i_d = ramp_i_q;
        ramp_q_d = ramp_q_q;
        uf_inc   = 1'b0;
        if (last_slot) begin
            case (src)
                MODE_RAMP: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        hold_i_d[c*SAMPLE_W +: SAMPLE_W] = (c == 0) ? ramp_i_q : ~ramp_i_q;
                        hold_q_d[c*SAMPLE_W +: SAMPLE_W] = (c == 0) ? ramp_q_q : ~ramp_q_q;
                    end
                    ramp_i_d = ramp_i_q + STEP_I;
                    ramp_q_d = ramp_q_q + STEP_Q;
                end
                MODE_CONST: begin
                    hold_i_d = {NUM_CH{const_i}};
                    hold_q_d = {NUM_CH{const_q}};
                end
                MODE_PASS: begin
                    if (fifo_empty) begin
                        hold_i_d = '0;
                        hold_q_d = '0;
                        uf_inc   = 1'b1;
                    end else begin
                        hold_i_d = fifo_dat[DW-1:0];
                        hold_q_d = fifo_dat[2*DW-1:DW];
                    end
                end
                default: begin
                    hold_i_d = '0;
                    hold_q_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        uf_d = uf_q;
        if (clr_cnt) begin
            uf_d = '0;
        end else if (uf_inc && (uf_q != UF_MAX)) begin
            uf_d = uf_q + UF_W'(1);
        end
    end

    always_ff @(posedge rf_data_clk or negedge rst_b) begin
        if (!rst_b) begin
            slot_q   <= '0;
            wu_q     <= WU_INIT;
            en_q     <= 1'b0;
            hold_i_q <= {NUM_CH{RAMP_INIT_I}};
            hold_q_q <= {NUM_CH{RAMP_INIT_Q}};
            ramp_i_q <= RAMP_INIT_I + STEP_I;
            ramp_q_q <= RAMP_INIT_Q + STEP_Q;
            uf_q     <= '0;
            txi_q    <= '0;
            txq_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            wu_q     <= wu_d;
            en_q     <= en_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            ramp_i_q <= ramp_i_d;
            ramp_q_q <= ramp_q_d;
            uf_q     <= uf_d;
            txi_q    <= txi_d;
            txq_q    <= txq_d;
            frame_q  <= frame_d;
        end
    end

    assign s_ready       = en_q & ~fifo_full;
    assign tx_enable     = en_q;
    assign tx_frame      = frame_q;
    assign tx_data_i     = txi_q;
    assign tx_data_q     = txq_q;
    assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_lgdst_iq_tx_serializer.sv
// Bench for the I/Q serializer: single-channel instance against a queue-based frame model,
// plus a dual-channel instance checked with closed-form slot arithmetic.
module tb_lgdst_iq_tx_serializer;
    localparam int WU     = 30;
    localparam int DEPTH  = 8;
    localparam int INIT_I = 'hE80;
    localparam int INIT_Q = 'h5C0;
    localparam int STEP_I = 3;
    localparam int STEP_Q = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, s_valid, clr_cnt;
    logic [1:0]  mode, mode2;
    logic [11:0] const_i, const_q, const_i2, const_q2, s_i, s_q;
    logic [23:0] zero24;
    logic        s_ready, tx_enable, tx_frame;
    logic [5:0]  tx_data_i, tx_data_q;
    logic [7:0]  underflow_cnt;
    logic        s_ready2, tx_enable2, tx_frame2;
    logic [5:0]  tx_data_i2, tx_data_q2;
    logic [7:0]  underflow_cnt2;

    lgdst_iq_tx_serializer u_dut (
        .rf_data_clk(clk), .rst_b(rst_b), .mode(mode), .const_i(const_i), .const_q(const_q),
        .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q), .clr_cnt(clr_cnt),
        .tx_enable(tx_enable), .tx_frame(tx_frame), .tx_data_i(tx_data_i),
        .tx_data_q(tx_data_q), .underflow_cnt(underflow_cnt)
    );

    lgdst_iq_tx_serializer #(.NUM_CH(2)) u_dut2 (
        .rf_data_clk(clk), .rst_b(rst_b), .mode(mode2), .const_i(const_i2), .const_q(const_q2),
        .s_valid(1'b0), .s_ready(s_ready2), .s_i(zero24), .s_q(zero24), .clr_cnt(1'b0),
        .tx_enable(tx_enable2), .tx_frame(tx_frame2), .tx_data_i(tx_data_i2),
        .tx_data_q(tx_data_q2), .underflow_cnt(underflow_cnt2)
    );

    logic [22:0] obs1;
    assign obs1 = {tx_enable, s_ready, tx_frame, tx_data_i, tx_data_q, underflow_cnt};

    int          npass = 0;
    int          ntotal = 0;
    logic [23:0] m_fifo[$];
    int          m_cyc, m_hold_i, m_hold_q, m_ramp_i, m_ramp_q, m_uf;
    logic [22:0] exp1;

    task automatic model_reset();
        m_fifo.delete();
        m_cyc    = 0;
        m_hold_i = INIT_I;
        m_hold_q = INIT_Q;
        m_ramp_i = (INIT_I + STEP_I) % 4096;
        m_ramp_q = (INIT_Q + STEP_Q) % 4096;
        m_uf     = 0;
        exp1     = '0;
    endtask

    // One clock edge: frame-level model of the single-channel instance, then settle.
    task automatic tick();
        bit          en, pushed, got, uf_inc;
        logic [23:0] word;
        int          slot, src;
        logic [5:0]  oi, oq;
        @(posedge clk);
        en     = (m_cyc >= WU);
        slot   = m_cyc % 2;
        pushed = s_valid && en && (m_fifo.size() < DEPTH);
        oi     = 6'((slot == 0) ? (m_hold_i >> 6) : m_hold_i);
        oq     = 6'((slot == 0) ? (m_hold_q >> 6) : m_hold_q);
        uf_inc = 0;
        got    = 0;
        word   = '0;
        if (slot == 1) begin
            if (en && m_fifo.size() > 0) begin
                word = m_fifo.pop_front();
                got  = 1;
            end
            src = en ? int'(mode) : 1;
            case (src)
                0: begin
                    m_hold_i = got ? int'(word[11:0]) : 0;
                    m_hold_q = got ? int'(word[23:12]) : 0;
                    uf_inc   = !got;
                end
                1: begin
                    m_hold_i = m_ramp_i;
                    m_hold_q = m_ramp_q;
                    m_ramp_i = (m_ramp_i + STEP_I) % 4096;
                    m_ramp_q = (m_ramp_q + STEP_Q) % 4096;
                end
                2: begin
                    m_hold_i = int'(const_i);
                    m_hold_q = int'(const_q);
                end
                default: begin
                    m_hold_i = 0;
                    m_hold_q = 0;
                end
            endcase
        end
        if (pushed) m_fifo.push_back({s_q, s_i});
        if (clr_cnt) m_uf = 0;
        else if (uf_inc && m_uf < 255) m_uf++;
        m_cyc++;
        exp1 = {m_cyc >= WU, (m_cyc >= WU) && (m_fifo.size() < DEPTH), slot == 0, oi, oq, 8'(m_uf)};
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #1;
        ntotal++;
        if (obs1 !== 23'd0 || tx_enable2 !== 1'b0 || s_ready2 !== 1'b0)
            $display("FAIL reset_async: got %h/%b want 0/0", obs1, tx_enable2);
        else npass++;
        repeat (2) @(posedge clk);
        #1;
        ntotal++;
        if (obs1 !== 23'd0 || {tx_frame2, tx_data_i2, tx_data_q2} !== 13'd0)
            $display("FAIL reset_held: got %h/%h want 0", obs1, {tx_frame2, tx_data_i2, tx_data_q2});
        else npass++;
        model_reset();
        rst_b = 1'b1;
    endtask

    task automatic test_warmup();
        logic [12:0] tab [4] = '{{1'b1, 6'h3A, 6'h17}, {1'b0, 6'h00, 6'h00},
                                 {1'b1, 6'h3A, 6'h17}, {1'b0, 6'h03, 6'h07}};
        int          s2, f, vi, vq;
        logic [12:0] e2;
        mode = 2'd2; const_i = 12'hFFF; const_q = 12'hFFF; mode2 = 2'd3;
        for (int n = 1; n <= WU + 2; n++) begin
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL warmup_model edge %0d: got %h want %h", n, obs1, exp1);
            else npass++;
            if (n <= 4) begin
                ntotal++;
                if ({tx_frame, tx_data_i, tx_data_q} !== tab[n-1])
                    $display("FAIL first_frames edge %0d: got %h want %h", n, {tx_frame, tx_data_i, tx_data_q}, tab[n-1]);
                else npass++;
            end
            if (n >= WU - 1) begin
                ntotal++;
                if ({tx_enable, tx_enable2} !== ((n >= WU) ? 2'b11 : 2'b00))
                    $display("FAIL tx_enable_edge edge %0d: got %b%b want %0d", n, tx_enable, tx_enable2, n >= WU);
                else npass++;
            end
            if (n <= 8) begin
                s2 = (n - 1) % 4;
                f  = (n - 1) / 4;
                vi = (INIT_I + f * STEP_I) % 4096;
                vq = (INIT_Q + f * STEP_Q) % 4096;
                if (f > 0 && s2 >= 2) begin
                    vi = vi ^ 'hFFF;
                    vq = vq ^ 'hFFF;
                end
                e2 = {s2 < 2, 6'((s2 % 2 == 1) ? vi : vi >> 6), 6'((s2 % 2 == 1) ? vq : vq >> 6)};
                ntotal++;
                if ({tx_frame2, tx_data_i2, tx_data_q2} !== e2)
                    $display("FAIL ramp_2ch edge %0d: got %h want %h", n, {tx_frame2, tx_data_i2, tx_data_q2}, e2);
                else npass++;
            end
        end
    endtask

    task automatic test_pass_latency();
        mode = 2'd0;
        while (m_cyc % 2 != 0) tick();
        s_i = 12'hABC; s_q = 12'h123; s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            s_valid = 1'b0;
            ntotal++;
            if (obs1 !== exp1) $display("FAIL pass_model step %0d: got %h want %h", k, obs1, exp1);
            else npass++;
            if (k >= 2) begin
                ntotal++;
                if ({tx_frame, tx_data_i, tx_data_q} !== ((k == 2) ? {1'b1, 6'h2A, 6'h04} : {1'b0, 6'h3C, 6'h23}))
                    $display("FAIL pass_latency step %0d: got %h", k, {tx_frame, tx_data_i, tx_data_q});
                else npass++;
            end
        end
    endtask

    task automatic test_random();
        mode = 2'd0;
        for (int k = 0; k < 300; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_i     = 12'($urandom);
            s_q     = 12'($urandom);
            const_i = 12'($urandom);
            const_q = 12'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            clr_cnt = ($urandom_range(0, 31) == 0);
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL random cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
        s_valid = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic test_underflow();
        mode = 2'd0;
        for (int k = 0; k < 620; k++) begin
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL starve cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
        ntotal++;
        if ({underflow_cnt, tx_data_i, tx_data_q} !== {8'd255, 12'd0})
            $display("FAIL underflow_sat: got %h want ff000", {underflow_cnt, tx_data_i, tx_data_q});
        else npass++;
        while (m_cyc % 2 != 1) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        ntotal++;
        if (underflow_cnt !== 8'd0) $display("FAIL clr_priority: got %0d want 0", underflow_cnt);
        else npass++;
        repeat (2) tick();
        ntotal++;
        if (obs1 !== exp1) $display("FAIL count_after_clr: got %h want %h", obs1, exp1);
        else npass++;
    endtask

    task automatic test_const2();
        int s2;
        mode2 = 2'd2; const_i2 = 12'hFFF; const_q2 = 12'h001;
        repeat (8) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            s2 = (m_cyc - 1) % 4;
            ntotal++;
            if ({tx_enable2, tx_frame2, tx_data_i2, tx_data_q2} !== {1'b1, s2 < 2, 6'h3F, (s2 % 2 == 1) ? 6'h01 : 6'h00})
                $display("FAIL const_2ch slot %0d: got %h", s2, {tx_enable2, tx_frame2, tx_data_i2, tx_data_q2});
            else npass++;
        end
    endtask

    task automatic test_fill();
        bit saw_block = 0;
        mode = 2'd3;
        s_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            s_i = 12'($urandom);
            s_q = 12'($urandom);
            tick();
            if (s_ready === 1'b0) saw_block = 1;
            ntotal++;
            if (obs1 !== exp1) $display("FAIL fill cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
        ntotal++;
        if (saw_block !== 1'b1) $display("FAIL full_blocks: got %b want 1", saw_block);
        else npass++;
        s_valid = 1'b0;
        mode = 2'd0;
        for (int k = 0; k < 20; k++) begin
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL drain cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd3;
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_i = 12'($urandom);
            s_q = 12'($urandom);
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL prefill cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
        s_valid = 1'b0;
        while (m_cyc % 2 != 1) tick();
        rst_b = 1'b0;
        #1;
        ntotal++;
        if (obs1 !== 23'd0 || {tx_enable2, tx_frame2, tx_data_i2, tx_data_q2} !== 14'd0)
            $display("FAIL reset_mid: got %h/%h want 0", obs1, {tx_enable2, tx_frame2, tx_data_i2, tx_data_q2});
        else npass++;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_b = 1'b1;
        test_warmup();
        mode = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            ntotal++;
            if (obs1 !== exp1) $display("FAIL post_reset cycle %0d: got %h want %h", k, obs1, exp1);
            else npass++;
        end
    endtask

    initial begin
        rst_b = 1'b1; s_valid = 1'b0; clr_cnt = 1'b0; mode = 2'd0; mode2 = 2'd1;
        const_i = '0; const_q = '0; const_i2 = '0; const_q2 = '0;
        s_i = '0; s_q = '0; zero24 = '0;
        model_reset();
        #2;
        test_reset();
        test_warmup();
        test_pass_latency();
        test_random();
        test_underflow();
        test_const2();
        test_fill();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/lgdst_iq_tx_serializer.md
Name: lgdst_iq_tx_serializer

Overview:
- Parametrised I/Q transmit serializer for the RF transceiver's half-width LVDS data port.
- Accepts full-width I/Q samples (1 or 2 channels) through a valid/ready stream into a small FIFO.
- Selects a source per frame: pass-through, ramp, constant or mute.
- Splits each sample into MSB/LSB halves with a frame strobe, and gates tx_enable behind a warm-up countdown.
- Sits between the modem datapath and the RF chip pins, in the rf_data_clk domain.

Parameters:
- SAMPLE_W, 12, I/Q sample width; must equal 2*BUS_W.
- BUS_W, 6, pin bus width per I and Q.
- NUM_CH, 1, channel count; 1 or 2.
- FIFO_DEPTH, 8, input FIFO words; power of 2, at least 2.
- WARMUP_CYCLES, 30, cycles from reset release to tx_enable; 1..255.
- RAMP_INIT_I, 12'hE80, ramp I seed.
- RAMP_INIT_Q, 12'h5C0, ramp Q seed.
- RAMP_STEP_I, 3, I increment per frame.
- RAMP_STEP_Q, 7, Q increment per frame.

Ports:
- rf_data_clk  in  1  sole clock.
- rst_b  in  1  asynchronous active-low reset.
- mode  in  2  0 pass-through, 1 ramp, 2 constant, 3 mute.
- const_i  in  SAMPLE_W  constant-mode I, applied to all channels.
- const_q  in  SAMPLE_W  constant-mode Q.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_i  in  NUM_CH*SAMPLE_W  I samples, ch0 in LSBs.
- s_q  in  NUM_CH*SAMPLE_W  Q samples, ch0 in LSBs.
- clr_cnt  in  1  synchronous clear of underflow_cnt.
- tx_enable  out  1  high once warm-up has expired.
- tx_frame  out  1  frame strobe.
- tx_data_i  out  BUS_W  I half-sample.
- tx_data_q  out  BUS_W  Q half-sample.
- underflow_cnt  out  8  saturating count of pass-through fetches that found the FIFO empty.

Behaviour:
- Clock/reset: single clock rf_data_clk; rst_b is asynchronous, active-low. All state is cleared asynchronously.
- Reset values:
  - tx_data_i/q = 0, tx_frame = 0, tx_enable = 0, s_ready = 0, underflow_cnt = 0.
  - FIFO empty, slot = 0, warm-up counter = WARMUP_CYCLES.
  - hold = {RAMP_INIT_I, RAMP_INIT_Q} replicated per channel.
  - ramp = INIT+STEP.
- Reset asserted mid-frame aborts the frame immediately; no partial word is retained.
- Warm-up:
  - Counter decrements each cycle while nonzero; tx_enable = (counter == 0), registered.
  - Exactly WARMUP_CYCLES cycles after reset release, then sticky until reset.
  - During warm-up the source is forced to ramp regardless of mode, and s_ready = 0.
- Slots:
  - NSLOT = 2*NUM_CH; slot counter runs 0..NSLOT-1 continuously from reset release and wraps.
  - NUM_CH=1: slot0 = ch0 MSB (frame=1), slot1 = ch0 LSB (frame=0).
  - NUM_CH=2: slot0 = ch0 MSB (frame=1), slot1 = ch0 LSB (frame=1), slot2 = ch1 MSB (frame=0), slot3 = ch1 LSB (frame=0).
- Output stage: on each edge, tx_* are registered from the hold half selected by the current slot. Outputs are therefore one cycle behind slot.
- Fetch: on the edge where slot == NSLOT-1, hold loads the next word according to the source:
  - ramp: hold <= ramp value, then ramp += STEP modulo 2^SAMPLE_W. For NUM_CH=2, ch1 = bitwise inverse of ch0.
  - constant: const_i/const_q on every channel.
  - mute: zeros.
  - pass-through, FIFO non-empty: pop the FIFO into hold.
  - pass-through, FIFO empty: hold <= zeros and underflow_cnt increments, saturating at 255.
- Mode changes take effect only at the next fetch; a frame is never mixed.
- Non-pass-through modes after warm-up: FIFO still pops at each fetch and the data is discarded; underflow is not counted.
- FIFO:
  - s_ready = tx_enable & !full.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - No push when full; pop on empty is a no-op.
- Latency: a word written into an empty FIFO on edge k, with slot == NSLOT-1 at edge k+1, reaches tx MSB at edge k+2. This is the minimum.
- clr_cnt has priority over an increment in the same cycle.

Decomposition:
- Package lgdst_iq_pkg:
  - mode encodings MODE_PASS/RAMP/CONST/MUTE;
  - function for slot-counter width clog2(2*NUM_CH);
  - underflow counter width constant.
- Sub-module lgdst_iq_sync_fifo: single-clock, parametrised width and depth, full/empty flags, async active-low reset.

Test Plan:
- Reset release, defaults, NUM_CH=1:
  - tx_enable rises exactly 30 cycles after release.
  - First frame: I = 3A/00, Q = 17/00, frame 1/0.
  - Second frame: I = 3A/03, Q = 17/07.
- Pass-through after warm-up:
  - Push I=0xABC, Q=0x123 → tx_data_i 0x2A then 0x3C, tx_data_q 0x04 then 0x23, with frame 1 then 0.
  - Minimum latency of 2 cycles is met when the push is aligned to the last slot.
- Starve the FIFO for 300 fetches in pass-through:
  - Outputs are all zeros and underflow_cnt saturates at 255.
  - clr_cnt asserted with a coincident underflow → 0.
- NUM_CH=2, constant mode, const_i=0xFFF, const_q=0x001:
  - Per frame: frame 1,1,0,0; I 3F,3F,3F,3F; Q 00,01,00,01.
- Fill the FIFO to 8 words:
  - s_ready deasserts.
  - Pops resume at each fetch; push and pop in the same cycle hold occupancy.
- Assert rst_b low mid-frame (slot 1):
  - Outputs, FIFO, counters and tx_enable clear immediately.
  - The warm-up sequence restarts with the same first-frame values.
